// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler driving the select of a shared 8:1 mux.
// Optional forced release after TIMEOUT held cycles when MUX8_RR_SCHED_TIMEOUT_EN is defined.
module mux8_rr_sched #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       timeout
);

  localparam int unsigned N_SRC = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_d;
  logic [7:0] gnt_d;
  logic       valid_d;
  logic [2:0] win_idx;
  logic       win_found;
  logic [2:0] cand;
  logic       tmo_c;

  // Bad TIMEOUT values are rejected at elaboration.
  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("mux8_rr_sched: TIMEOUT out of range 2..255");
  end

`ifdef MUX8_RR_SCHED_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       tmo_pulse_d;

  assign tmo_c = (hold_q == 8'(TIMEOUT - 1));
`else
  assign tmo_c   = 1'b0;
  assign timeout = 1'b0;
`endif

  // First requesting source at or above ptr, wrapping 7 -> 0.
  always_comb begin
    win_idx   = 3'd0;
    win_found = 1'b0;
    cand      = 3'd0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel;
    gnt_d   = gnt;
    valid_d = valid;
`ifdef MUX8_RR_SCHED_TIMEOUT_EN
    hold_d      = hold_q;
    tmo_pulse_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = BUSY;
          gnt_d   = 8'(1) << win_idx;
          sel_d   = win_idx;
          valid_d = 1'b1;
`ifdef MUX8_RR_SCHED_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end
      end
      BUSY: begin
`ifdef MUX8_RR_SCHED_TIMEOUT_EN
        hold_d = hold_q + 8'd1;
`endif
        // A normal release takes priority over the timeout.
        if (done || !req[sel]) begin
          state_d = IDLE;
          gnt_d   = 8'h00;
          valid_d = 1'b0;
          ptr_d   = sel + 3'd1;
        end else if (tmo_c) begin
          state_d = IDLE;
          gnt_d   = 8'h00;
          valid_d = 1'b0;
          ptr_d   = sel + 3'd1;
`ifdef MUX8_RR_SCHED_TIMEOUT_EN
          tmo_pulse_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel     <= 3'd0;
      gnt     <= 8'h00;
      valid   <= 1'b0;
`ifdef MUX8_RR_SCHED_TIMEOUT_EN
      hold_q  <= 8'd0;
      timeout <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel     <= sel_d;
      gnt     <= gnt_d;
      valid   <= valid_d;
`ifdef MUX8_RR_SCHED_TIMEOUT_EN
      hold_q  <= hold_d;
      timeout <= tmo_pulse_d;
`endif
    end
  end

endmodule

// File: doc/mux8_rr_sched.md
MUX8_RR_SCHED -- requirements
Module: mux8_rr_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles a grant is held before forced release (used only when MUX8_RR_SCHED_TIMEOUT_EN is defined; legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-004 SHALL have port req, input, 8, one request bit per 8:1 mux source; req[i] set means source a[i] wants the shared output.
REQ-005 SHALL have port done, input, 1, the current owner's release strobe; sampled only while a grant is held.
REQ-006 SHALL have port sel, output, 3, the registered select code for the 8:1 mux; sel == index of the granted source.
REQ-007 SHALL have port gnt, output, 8, the registered one-hot grant vector; all zero when nothing is granted.
REQ-008 SHALL have port valid, output, 1, high exactly when gnt is non-zero.
REQ-009 SHALL have port timeout, output, 1, a one-cycle pulse on forced release.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (gnt=0, valid=0) and BUSY (exactly one gnt bit set, valid=1).
REQ-011 SHALL keep a 3-bit round-robin pointer ptr; arbitration searches req from index ptr upward, wrapping 7->0, and picks the first set bit.
REQ-012 IDLE with req==0 SHALL stay in IDLE; outputs unchanged; sel holds its last value.
REQ-013 IDLE with req!=0 SHALL go to BUSY on the next edge, loading gnt with the one-hot winner and sel with its index; request-to-grant latency is 1 cycle.
REQ-014 BUSY SHALL hold gnt and sel stable regardless of other req changes.
REQ-015 BUSY SHALL release on the next edge when done=1 or req[sel]=0; release means going to IDLE with gnt=0, valid=0, and ptr=sel+1 (mod 8).
REQ-016 done=1 together with req[sel]=1 in the same cycle SHALL still release; done while IDLE SHALL be ignored.
REQ-017 After a release there SHALL be exactly one IDLE cycle before the next grant, so back-to-back grants are spaced 1 bubble apart.
REQ-018 The scheduler SHALL give no requester two consecutive grants while another requester holds req=1 continuously, and SHALL serve every continuously requesting source within 8 grants.
REQ-019 sel SHALL change only on the edge that enters BUSY.

Reset
REQ-020 rst=1 at an edge SHALL force IDLE, gnt=8'h00, valid=0, sel=3'd0, ptr=3'd0, timeout=0, and the hold counter to 0.
REQ-021 rst asserted during BUSY SHALL drop the grant at that edge, with no timeout pulse; the first grant after reset searches from index 0.

Configuration
REQ-022 With macro MUX8_RR_SCHED_TIMEOUT_EN defined, an 8-bit hold counter SHALL clear on entry to BUSY and increment each BUSY cycle; when a grant has been held TIMEOUT cycles without a release, the block SHALL release as in REQ-015 and pulse timeout=1 for the cycle after the release edge.
REQ-023 When the timeout and a normal release coincide, the normal release SHALL win and no timeout pulse SHALL occur.
REQ-024 Without MUX8_RR_SCHED_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be tied 0, and grants SHALL be held indefinitely until done or req drop.

Verification
REQ-025 Reset then req=8'h00 for 10 cycles -> gnt=0, valid=0, sel=0 throughout.
REQ-026 After reset, req=8'h90, then done pulse after 3 BUSY cycles -> grants in order: gnt=8'h10/sel=4, one bubble, gnt=8'h80/sel=7, one bubble, gnt=8'h10.
REQ-027 req=8'hFF held, done pulsed every 2nd BUSY cycle -> sel sequence 0,1,2,...,7,0; the grant is never repeated back to back.
REQ-028 Grant to 3 (ptr at 3), then req[3] drops without done -> release next edge, ptr=4; with req=8'h09 the next grant is gnt=8'h01 (wrap).
REQ-029 With TIMEOUT_EN and TIMEOUT=4, req=8'h04 held with no done -> gnt=8'h04 for 4 cycles, 1 IDLE cycle with timeout=1, then re-grant 8'h04; without the macro, gnt=8'h04 is held for 100 cycles with timeout=0.
REQ-030 rst pulsed on the 2nd BUSY cycle of a grant to 6 -> next cycle gnt=0, sel=0; with req=8'h41 the next grant is gnt=8'h01.
